// File: rtl/avr_bus_master_pkg.sv
// ---------------------------------------------------------------------------
// avr_bus_master_pkg
//   Shared constants for the AVR external-memory bus master: the AVR
//   multiplexed-bus widths, the FSM state encoding and a helper that sizes
//   the strobe wait counter.
// ---------------------------------------------------------------------------
package avr_bus_master_pkg;

  // AVR external bus geometry: 16-bit address, low byte multiplexed on AD.
  localparam int AVR_ADDR_WIDTH = 16;
  localparam int AVR_AD_WIDTH   = 8;
  localparam int AVR_AH_WIDTH   = 8;

  // FSM state encoding (plain constants so older tools can consume them).
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ALE       = 3'd1;
  localparam logic [2:0] ST_ADDR_HOLD = 3'd2;
  localparam logic [2:0] ST_STROBE    = 3'd3;
  localparam logic [2:0] ST_RECOVER   = 3'd4;

  // Wait counter must hold 0..ws; never narrower than one bit.
  function automatic int wait_cnt_width(input int ws);
    return (ws < 1) ? 1 : $clog2(ws + 1);
  endfunction

endpackage

// File: rtl/avr_bus_master.sv
// ---------------------------------------------------------------------------
// avr_bus_master
//   Single-access master for the AVR multiplexed external-memory bus.
//   A request accepted in IDLE runs ALE -> ADDR_HOLD -> STROBE (1+WAIT_STATES
//   cycles) -> RECOVER and back to IDLE. Every bus-facing output is a flop,
//   so strobes and ALE are glitch-free.
//
// Ports
//   clk      system clock, rising edge
//   _reset   asynchronous active-low reset
//   req/we/addr/wdata  request; sampled only while idle
//   busy     high from the cycle after acceptance until back in IDLE
//   done     one-cycle completion pulse (RECOVER cycle)
//   rdata    read data, valid with done, held until the next read completes
//   _mpu_rd, _mpu_wr  active-low bus strobes
//   mpu_ale  address latch enable
//   mpu_ah   upper address byte
//   mpu_ad   multiplexed low-address / data bus (tri-state)
// ---------------------------------------------------------------------------
module avr_bus_master
  import avr_bus_master_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int ADDR_WIDTH  = AVR_ADDR_WIDTH,
  parameter int DATA_WIDTH  = AVR_AD_WIDTH
) (
  input  logic                    clk,
  input  logic                    _reset,
  input  logic                    req,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    _mpu_rd,
  output logic                    _mpu_wr,
  output logic                    mpu_ale,
  output logic [AVR_AH_WIDTH-1:0] mpu_ah,
  inout  wire  [AVR_AD_WIDTH-1:0] mpu_ad
);

  localparam int WAIT_W = wait_cnt_width(WAIT_STATES);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_STATES);

  logic [2:0]              state_q, state_d;
  logic [WAIT_W-1:0]       wait_q, wait_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    rd_n_q, rd_n_d;
  logic                    wr_n_q, wr_n_d;
  logic                    ale_q, ale_d;
  logic [AVR_AH_WIDTH-1:0] ah_q, ah_d;
  logic                    ad_oe_q, ad_oe_d;
  logic [AVR_AD_WIDTH-1:0] ad_out_q, ad_out_d;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ah_d    = ah_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_ALE;
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          ah_d    = addr[AVR_AD_WIDTH +: AVR_AH_WIDTH];
        end
      end
      ST_ALE:       state_d = ST_ADDR_HOLD;
      ST_ADDR_HOLD: begin
        state_d = ST_STROBE;
        wait_d  = '0;
      end
      ST_STROBE: begin
        if (wait_q == WAIT_LAST) begin
          state_d = ST_RECOVER;
          wait_d  = '0;
          // Capture on the edge that closes the last strobe cycle, while the
          // slave is still driving the bus.
          if (!we_q) rdata_d = DATA_WIDTH'(mpu_ad);
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_RECOVER:   state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase

    // Bus outputs are decoded from the next state and then registered, so
    // each output is valid for exactly the cycles its state occupies.
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_RECOVER);
    ale_d    = (state_d == ST_ALE);
    rd_n_d   = !((state_d == ST_STROBE) && !we_d);
    wr_n_d   = !((state_d == ST_STROBE) && we_d);
    // Writes keep driving data through RECOVER for hold time; reads release
    // the bus from STROBE onwards.
    ad_oe_d  = (state_d == ST_ALE) || (state_d == ST_ADDR_HOLD) ||
               (((state_d == ST_STROBE) || (state_d == ST_RECOVER)) && we_d);
    ad_out_d = ((state_d == ST_ALE) || (state_d == ST_ADDR_HOLD)) ?
               addr_d[AVR_AD_WIDTH-1:0] : AVR_AD_WIDTH'(wdata_d);
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state_q  <= ST_IDLE;
      wait_q   <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      ale_q    <= 1'b0;
      ah_q     <= '0;
      ad_oe_q  <= 1'b0;
      ad_out_q <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rd_n_q   <= rd_n_d;
      wr_n_q   <= wr_n_d;
      ale_q    <= ale_d;
      ah_q     <= ah_d;
      ad_oe_q  <= ad_oe_d;
      ad_out_q <= ad_out_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rdata   = rdata_q;
  assign _mpu_rd = rd_n_q;
  assign _mpu_wr = wr_n_q;
  assign mpu_ale = ale_q;
  assign mpu_ah  = ah_q;
  assign mpu_ad  = ad_oe_q ? ad_out_q : {AVR_AD_WIDTH{1'bz}};

endmodule
